// File: rtl/keccak_pkg.sv
// Shared constants and types for the Keccak absorb path.
package keccak_pkg;

  localparam int MAX_RATE_BYTES = 168;
  localparam int RATE_WIDTH     = 11;

  localparam logic [7:0] PAD_END_BYTE = 8'h80;
  localparam logic [7:0] DS_SHA3      = 8'h06;
  localparam logic [7:0] DS_SHAKE     = 8'h1F;

  typedef enum logic [1:0] {
    FILL,
    FLUSH,
    PADBLK
  } absorb_stream_state_e;

endpackage

// File: rtl/absorb_byte_place.sv
// Places one input beat into the rate buffer at a byte offset; bytes past R spill
// into a carry vector that starts at carry byte 0.
module absorb_byte_place
  import keccak_pkg::*;
#(
  parameter int BPB = 32
) (
  input  logic [BPB*8-1:0]            beat_i,
  input  logic [7:0]                  n_i,
  input  logic [7:0]                  off_i,
  input  logic [7:0]                  rbytes_i,
  output logic [MAX_RATE_BYTES-1:0]   mask_o,
  output logic [MAX_RATE_BYTES*8-1:0] data_o,
  output logic [BPB*8-1:0]            carry_o,
  output logic [7:0]                  c_o
);

  localparam int IW = $clog2(BPB);

  logic [BPB-1:0][7:0]            beat;
  logic [MAX_RATE_BYTES-1:0][7:0] data;
  logic [BPB-1:0][7:0]            carry;
  logic [8:0]                     end_w;
  logic [8:0]                     r9;
  logic [8:0]                     off9;

  assign beat  = beat_i;
  assign off9  = {1'b0, off_i};
  assign r9    = {1'b0, rbytes_i};
  assign end_w = off9 + {1'b0, n_i};
  assign c_o   = (end_w > r9) ? 8'(end_w - r9) : 8'd0;

  always_comb begin
    mask_o = '0;
    data   = '0;
    for (int j = 0; j < MAX_RATE_BYTES; j++) begin
      if (9'(j) >= off9 && 9'(j) < end_w && 9'(j) < r9) begin
        mask_o[j] = 1'b1;
        data[j]   = beat[IW'(9'(j) - off9)];
      end
    end
  end

  // Carry byte k is beat byte (R - off + k); only meaningful while off < R.
  always_comb begin
    carry = '0;
    for (int k = 0; k < BPB; k++) begin
      if (r9 - off9 + 9'(k) < {1'b0, n_i})
        carry[k] = beat[IW'(r9 - off9 + 9'(k))];
    end
  end

  assign data_o  = data;
  assign carry_o = carry;

endmodule

// File: rtl/keccak_absorb_stream.sv
// Streaming absorb front-end: packs beats into rate-sized blocks, carries beat
// overflow into the next block and applies multi-rate padding.
module keccak_absorb_stream
  import keccak_pkg::*;
#(
  parameter  int DWIDTH = 256,
  localparam int BPB    = DWIDTH / 8
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [RATE_WIDTH-1:0]       rate_i,
  input  logic [7:0]                  dsbyte_i,
  input  logic                        s_valid_i,
  output logic                        s_ready_o,
  input  logic [DWIDTH-1:0]           s_data_i,
  input  logic [BPB-1:0]              s_keep_i,
  input  logic                        s_last_i,
  output logic                        blk_valid_o,
  input  logic                        blk_ready_i,
  output logic [MAX_RATE_BYTES*8-1:0] blk_o,
  output logic                        blk_last_o
);

  absorb_stream_state_e state_q, state_d;

  logic [MAX_RATE_BYTES-1:0][7:0] buf_q, buf_d;
  logic [BPB-1:0][7:0]            carry_q, carry_d;
  logic [7:0] cnt_q, cnt_d, c_q, c_d, r_q, r_d, ds_q, ds_d;
  logic       last_q, last_d, pad_pend_q, pad_pend_d;
  logic       carry_last_q, carry_last_d, msg_q, msg_d;

  logic [7:0] n, r_eff, ds_eff;
  logic [8:0] sum;
  logic       accept, flush_hs;

  logic [MAX_RATE_BYTES-1:0]      pl_mask;
  logic [MAX_RATE_BYTES-1:0][7:0] pl_data;
  logic [BPB-1:0][7:0]            pl_carry;
  logic [7:0]                     pl_c;

  always_comb begin
    n = '0;
    for (int i = 0; i < BPB; i++) n = n + {7'd0, s_keep_i[i]};
  end

  // First beat of a message uses the live rate/dsbyte; later beats the latched copy.
  assign r_eff    = msg_q ? r_q  : 8'(rate_i >> 3);
  assign ds_eff   = msg_q ? ds_q : dsbyte_i;
  assign sum      = {1'b0, cnt_q} + {1'b0, n};
  assign accept   = s_valid_i & s_ready_o;
  assign flush_hs = blk_valid_o & blk_ready_i;

  absorb_byte_place #(.BPB(BPB)) u_place (
    .beat_i   (s_data_i),
    .n_i      (n),
    .off_i    (cnt_q),
    .rbytes_i (r_eff),
    .mask_o   (pl_mask),
    .data_o   (pl_data),
    .carry_o  (pl_carry),
    .c_o      (pl_c)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= FILL;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FILL:
        if (accept && (s_last_i || sum >= {1'b0, r_eff})) state_d = FLUSH;
      FLUSH:
        if (blk_ready_i) begin
          if (c_q != 8'd0)    state_d = carry_last_q ? FLUSH : FILL;
          else if (pad_pend_q) state_d = PADBLK;
          else                 state_d = FILL;
        end
      PADBLK:
        state_d = FLUSH;
      default:
        state_d = FILL;
    endcase
  end

  always_comb begin
    s_ready_o   = (state_q == FILL);
    blk_valid_o = (state_q == FLUSH);
    blk_last_o  = (state_q == FLUSH) && last_q;
  end

  assign blk_o = buf_q;

  always_comb begin
    buf_d        = buf_q;
    carry_d      = carry_q;
    cnt_d        = cnt_q;
    c_d          = c_q;
    r_d          = r_q;
    ds_d         = ds_q;
    last_d       = last_q;
    pad_pend_d   = pad_pend_q;
    carry_last_d = carry_last_q;
    msg_d        = msg_q;

    if (state_q == FILL && accept) begin
      if (!msg_q) begin
        r_d   = r_eff;
        ds_d  = dsbyte_i;
        msg_d = 1'b1;
      end
      for (int j = 0; j < MAX_RATE_BYTES; j++)
        if (pl_mask[j]) buf_d[j] = pl_data[j];
      carry_d = pl_carry;
      c_d     = pl_c;
      if (s_last_i) begin
        if (sum < {1'b0, r_eff}) begin
          buf_d[sum[7:0]]     ^= ds_eff;
          buf_d[r_eff - 8'd1] ^= PAD_END_BYTE;
          last_d = 1'b1;
        end else if (sum == {1'b0, r_eff}) begin
          pad_pend_d = 1'b1;
        end else begin
          carry_last_d = 1'b1;
        end
      end else if (sum < {1'b0, r_eff}) begin
        cnt_d = sum[7:0];
      end
    end else if (flush_hs) begin
      buf_d = '0;
      if (c_q != 8'd0) begin
        buf_d[BPB-1:0] = carry_q;
        cnt_d   = c_q;
        c_d     = 8'd0;
        carry_d = '0;
        // Carry bytes above c are zero, so padding can be XORed in directly.
        if (carry_last_q) begin
          buf_d[c_q]        ^= ds_q;
          buf_d[r_q - 8'd1] ^= PAD_END_BYTE;
          last_d       = 1'b1;
          carry_last_d = 1'b0;
        end
      end else if (pad_pend_q) begin
        pad_pend_d = 1'b0;
        cnt_d      = 8'd0;
      end else begin
        cnt_d = 8'd0;
        if (last_q) begin
          last_d = 1'b0;
          msg_d  = 1'b0;
          r_d    = 8'd0;
          ds_d   = 8'd0;
        end
      end
    end else if (state_q == PADBLK) begin
      buf_d[0]          = ds_q;
      buf_d[r_q - 8'd1] = PAD_END_BYTE;
      last_d            = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      buf_q        <= '0;
      carry_q      <= '0;
      cnt_q        <= '0;
      c_q          <= '0;
      r_q          <= '0;
      ds_q         <= '0;
      last_q       <= 1'b0;
      pad_pend_q   <= 1'b0;
      carry_last_q <= 1'b0;
      msg_q        <= 1'b0;
    end else begin
      buf_q        <= buf_d;
      carry_q      <= carry_d;
      cnt_q        <= cnt_d;
      c_q          <= c_d;
      r_q          <= r_d;
      ds_q         <= ds_d;
      last_q       <= last_d;
      pad_pend_q   <= pad_pend_d;
      carry_last_q <= carry_last_d;
      msg_q        <= msg_d;
    end
  end

endmodule

// File: tb/tb_keccak_absorb_stream.sv
// Bench for keccak_absorb_stream: a 256-bit and a 64-bit instance checked against
// a message-level padding model.
module tb_keccak_absorb_stream;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [10:0] rate;
  logic [7:0]  ds;

  logic a_valid, a_ready, a_last, a_bvalid, a_bready, a_blast;
  logic [255:0]  a_data;
  logic [31:0]   a_keep;
  logic [1343:0] a_blk;

  logic b_valid, b_ready, b_last, b_bvalid, b_bready, b_blast;
  logic [63:0]   b_data;
  logic [7:0]    b_keep;
  logic [1343:0] b_blk;

  keccak_absorb_stream #(.DWIDTH(256)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .rate_i(rate), .dsbyte_i(ds),
    .s_valid_i(a_valid), .s_ready_o(a_ready), .s_data_i(a_data), .s_keep_i(a_keep),
    .s_last_i(a_last), .blk_valid_o(a_bvalid), .blk_ready_i(a_bready),
    .blk_o(a_blk), .blk_last_o(a_blast)
  );

  keccak_absorb_stream #(.DWIDTH(64)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .rate_i(rate), .dsbyte_i(ds),
    .s_valid_i(b_valid), .s_ready_o(b_ready), .s_data_i(b_data), .s_keep_i(b_keep),
    .s_last_i(b_last), .blk_valid_o(b_bvalid), .blk_ready_i(b_bready),
    .blk_o(b_blk), .blk_last_o(b_blast)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0]    msg [0:1023];
  logic [1343:0] got_blk [0:15];
  logic          got_last [0:15];
  int            ngot;

  task automatic chk(input string name, input logic [1343:0] act, input logic [1343:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Drives one message (which: 0 = 256-bit, 1 = 64-bit) and checks every block
  // against the padded message computed as a plain byte array.
  task automatic run_msg(input int which, input int len, input int rbits,
                         input logic [7:0] dsb, input bit rnd);
    int bpb, R, L, nexp, pos, cyc, nb;
    bit sent, extra_empty, v, lst, rdy, sr, bv, bl;
    logic [7:0]    pm [0:1279];
    logic [1343:0] exp_blk [0:15];
    logic [511:0]  d;
    logic [63:0]   kp;
    logic [1343:0] bo;
    bpb = (which != 0) ? 8 : 32;
    R   = rbits / 8;
    for (int i = 0; i < len; i++) msg[i] = 8'($urandom);
    L = (len / R + 1) * R;
    for (int i = 0; i < L; i++) pm[i] = (i < len) ? msg[i] : 8'h00;
    pm[len]   ^= dsb;
    pm[L-1]   ^= 8'h80;
    nexp = L / R;
    for (int k = 0; k < nexp; k++) begin
      exp_blk[k] = '0;
      for (int j = 0; j < R; j++) exp_blk[k][j*8 +: 8] = pm[k*R + j];
    end
    extra_empty = rnd && (len % bpb == 0) && (len > 0) && ($urandom % 2 == 0);
    rate = 11'(rbits);
    ds   = dsb;
    pos = 0; sent = 0; ngot = 0; cyc = 0;
    while ((!sent || ngot < nexp) && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      v   = !sent && (!rnd || ($urandom % 4 != 0));
      nb  = (len - pos > bpb) ? bpb : len - pos;
      lst = extra_empty ? (pos == len) : (len - pos <= bpb);
      for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom;
      for (int i = 0; i < nb; i++) d[i*8 +: 8] = msg[pos + i];
      kp = '0;
      for (int i = 0; i < nb; i++) kp[i] = 1'b1;
      if (!v) kp = '0;
      rdy = !rnd || ($urandom % 3 != 0);
      if (which != 0) begin
        b_valid = v; b_data = d[63:0]; b_keep = kp[7:0]; b_last = v && lst; b_bready = rdy;
      end else begin
        a_valid = v; a_data = d[255:0]; a_keep = kp[31:0]; a_last = v && lst; a_bready = rdy;
      end
      #1;
      sr = (which != 0) ? b_ready  : a_ready;
      bv = (which != 0) ? b_bvalid : a_bvalid;
      bl = (which != 0) ? b_blast  : a_blast;
      bo = (which != 0) ? b_blk    : a_blk;
      if (v && sr) begin
        pos += nb;
        if (lst) sent = 1;
      end
      if (bv && rdy) begin
        if (ngot < 16) begin
          got_blk[ngot]  = bo;
          got_last[ngot] = bl;
        end
        if (ngot < nexp) begin
          chk("blk_data", bo, exp_blk[ngot]);
          chk("blk_last", 1344'(bl), 1344'(ngot == nexp - 1));
        end
        ngot++;
      end
    end
    @(negedge clk);
    a_valid = 0; a_last = 0; b_valid = 0; b_last = 0; a_bready = 1; b_bready = 1;
    if (cyc >= 4000) begin
      checks++; errors++;
      $display("FAIL msg_timeout actual=%0d blocks required=%0d", ngot, nexp);
    end
    chk("blk_count", 1344'(ngot), 1344'(nexp));
    repeat (2) @(negedge clk);
    #1;
    chk("idle_after_msg", 1344'((which != 0) ? b_bvalid : a_bvalid), 1344'(0));
  endtask

  typedef struct {
    int         which;
    int         len;
    int         rbits;
    logic [7:0] dsb;
    int         nblk;
  } vec_t;

  vec_t tbl [8];
  int   rates [5] = '{1344, 1152, 1088, 832, 576};
  logic [1343:0] snap, expb;

  initial begin
    tbl[0] = '{0, 160, 1088, 8'h06, 2};
    tbl[1] = '{1,  72,  576, 8'h06, 2};
    tbl[2] = '{0, 135, 1088, 8'h06, 1};
    tbl[3] = '{0,   0, 1344, 8'h1F, 1};
    tbl[4] = '{0, 136, 1088, 8'h1F, 2};
    tbl[5] = '{1, 200, 1152, 8'h06, 2};
    tbl[6] = '{0, 300,  832, 8'h1F, 3};
    tbl[7] = '{1, 143, 1152, 8'h06, 1};

    rate = 11'd1088; ds = 8'h06;
    a_valid = 0; a_last = 0; a_data = '0; a_keep = '0; a_bready = 1;
    b_valid = 0; b_last = 0; b_data = '0; b_keep = '0; b_bready = 1;

    @(negedge clk); #1;
    chk("rst_s_ready",   1344'(a_ready),  1344'(1));
    chk("rst_blk_valid", 1344'(a_bvalid), 1344'(0));
    chk("rst_blk_last",  1344'(a_blast),  1344'(0));
    chk("rst_blk",       a_blk,           '0);
    chk("rst_b_ready",   1344'(b_ready),  1344'(1));
    @(negedge clk); rst_n = 1;

    for (int i = 0; i < 8; i++) begin
      run_msg(tbl[i].which, tbl[i].len, tbl[i].rbits, tbl[i].dsb, 1'b0);
      chk("tbl_nblk", 1344'(ngot), 1344'(tbl[i].nblk));
      case (i)
        0: begin
          chk("sha3_blk1_last", 1344'(got_last[0]), 1344'(0));
          chk("sha3_blk2_b0",   1344'(got_blk[1][7:0]), 1344'(msg[136]));
          chk("sha3_blk2_ds",   1344'(got_blk[1][24*8 +: 8]), 1344'(8'h06));
          chk("sha3_blk2_end",  1344'(got_blk[1][135*8 +: 8]), 1344'(8'h80));
        end
        1: begin
          chk("exact_blk1_last", 1344'(got_last[0]), 1344'(0));
          chk("exact_blk2_ds",   1344'(got_blk[1][7:0]), 1344'(8'h06));
          chk("exact_blk2_end",  1344'(got_blk[1][71*8 +: 8]), 1344'(8'h80));
          chk("exact_blk2_last", 1344'(got_last[1]), 1344'(1));
        end
        2: chk("combined_pad", 1344'(got_blk[0][135*8 +: 8]), 1344'(8'h86));
        3: begin
          chk("empty_b0",   1344'(got_blk[0][7:0]), 1344'(8'h1F));
          chk("empty_b167", 1344'(got_blk[0][167*8 +: 8]), 1344'(8'h80));
        end
        default: ;
      endcase
    end

    for (int t = 0; t < 12; t++)
      run_msg(int'($urandom % 2), int'($urandom_range(0, 400)),
              rates[$urandom % 5], 8'($urandom), 1'b1);

    // Backpressure: a full block with a 24-byte carry waits 10 cycles.
    rate = 11'd1088; ds = 8'h06;
    for (int b = 0; b < 5; b++) begin
      @(negedge clk);
      for (int i = 0; i < 8; i++) a_data[i*32 +: 32] = $urandom;
      for (int i = 0; i < 32; i++) msg[b*32 + i] = a_data[i*8 +: 8];
      a_valid = 1; a_keep = '1; a_last = 0; a_bready = 0;
    end
    @(negedge clk);
    a_valid = 0; a_keep = '0;
    #1;
    chk("bp_valid_t1", 1344'(a_bvalid), 1344'(1));
    expb = '0;
    for (int j = 0; j < 136; j++) expb[j*8 +: 8] = msg[j];
    chk("bp_blk", a_blk, expb);
    snap = a_blk;
    repeat (10) begin
      @(negedge clk); #1;
      chk("bp_s_ready", 1344'(a_ready), 1344'(0));
      chk("bp_blk_stable", a_blk, snap);
    end
    a_bready = 1;
    @(negedge clk); #1;
    chk("bp_resume_ready", 1344'(a_ready), 1344'(1));
    chk("bp_resume_valid", 1344'(a_bvalid), 1344'(0));
    a_valid = 1; a_keep = '0; a_last = 1;
    @(negedge clk);
    a_valid = 0; a_last = 0;
    #1;
    expb = '0;
    for (int j = 0; j < 24; j++) expb[j*8 +: 8] = msg[136 + j];
    expb[24*8 +: 8]  = 8'h06;
    expb[135*8 +: 8] = 8'h80;
    chk("bp_blk2", a_blk, expb);
    chk("bp_blk2_last", 1344'(a_blast), 1344'(1));
    @(negedge clk); #1;
    chk("bp_done", 1344'(a_bvalid), 1344'(0));

    // Reset mid-message, then a fresh message must carry no residue.
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      for (int i = 0; i < 8; i++) a_data[i*32 +: 32] = $urandom;
      a_valid = 1; a_keep = '1; a_last = 0;
    end
    @(negedge clk);
    a_valid = 0; a_keep = '0;
    rst_n = 0;
    #1;
    chk("mid_rst_ready", 1344'(a_ready),  1344'(1));
    chk("mid_rst_valid", 1344'(a_bvalid), 1344'(0));
    chk("mid_rst_last",  1344'(a_blast),  1344'(0));
    chk("mid_rst_blk",   a_blk,           '0);
    @(negedge clk);
    rst_n = 1;
    run_msg(0, 100, 1088, 8'h06, 1'b0);
    chk("post_rst_last", 1344'(got_last[0]), 1344'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
